// File: rtl/serial_subtractor.sv
// serial_subtractor -- digit-serial subtractor computing {bout, diff} = a - b - bin.
// A start request latches the operands. The FSM then runs N = WIDTH/DIGIT
// slices, least significant slice first, and spends one cycle in DONE while the
// registered result is presented.
// Optional feature: define SERIAL_SUBTRACTOR_FLAGS_EN to build the zero/ovf
// flag logic. Without it, zero and ovf are constant 0.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           accept;      // operands are being latched this cycle
  logic           last_slice;  // the final slice is being processed this cycle
  logic [CW-1:0]  cnt;

  // Operand shift registers. Bit slice [DIGIT-1:0] always holds the current slice.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  // Partial difference. It is internal only, so diff never shows a partial result.
  logic [WIDTH-1:0] acc;

  logic [DIGIT:0]   slice_res;
  logic [WIDTH-1:0] acc_next;

  // One slice subtraction. The extra top bit of the (DIGIT+1)-bit result is the
  // borrow into the next slice, which keeps the chain exact across slices.
  assign slice_res = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, borrow};

  // New slice enters at the top, and earlier slices move down toward bit 0.
  // After N slices the LSB slice has reached bit 0. The shift form also
  // covers DIGIT == WIDTH, where no earlier slice remains.
  assign acc_next = (WIDTH'(slice_res[DIGIT-1:0]) << (WIDTH - DIGIT)) | (acc >> DIGIT);

  assign last_slice = (state == RUN) && (cnt == LAST);

  // State register; reset overrides any operation in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values and simulation matches the synthesized registers.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and operand-accept strobe.
  always_comb begin
    // NOTE: defaults come first so that every path assigns every output and no
    // latch is inferred.
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // start is ignored here; only the slice count moves the FSM on.
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        // Back-to-back start is accepted exactly as from IDLE.
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Digit counter: cleared on accept and advanced once per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (accept)        cnt <= '0;
    else if (state == RUN)  cnt <= cnt + CW'(1);
  end

  // Operand and borrow datapath: load on accept, then shift one slice per RUN cycle.
  always_ff @(posedge clk) begin
    // NOTE: these registers have no reset. Their contents matter only after an
    // accept has loaded them, and reset already forces the FSM back to IDLE.
    if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
      acc    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      borrow <= slice_res[DIGIT];
      acc    <= acc_next;
    end
  end

  // Result registers: updated only on the edge that enters DONE, then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last_slice) begin
      diff <= acc_next;
      bout <= slice_res[DIGIT];
    end
  end

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  // The operand sign bits are captured at accept, because the shift
  // registers have moved them away by the time the flags are computed.
  logic a_msb;
  logic b_msb;
  logic zero_r;
  logic ovf_r;

  // Capture the operand sign bits when the operands are accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end
  end

  // Flag registers follow the same update rule as diff/bout.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (last_slice) begin
      zero_r <= (acc_next == '0);
      // Overflow: operands of opposite sign, and the result sign differs from the minuend.
      ovf_r  <= (a_msb != b_msb) && (acc_next[WIDTH-1] != a_msb);
    end
  end

  assign zero = zero_r;
  assign ovf  = ovf_r;
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor -- scoreboard bench for serial_subtractor.
// Two instances are exercised one after the other: dut0 (WIDTH=8, DIGIT=1)
// and dut1 (WIDTH=8, DIGIT=4). The driver pushes the expected result and its
// due cycle whenever it issues a start. A separate monitor pops an entry and
// compares it on every done pulse.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    int         id;
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    logic       ovf;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [2];
  logic [7:0] a_s     [2];
  logic [7:0] b_s     [2];
  logic       bin_s   [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic [7:0] diff_s  [2];
  logic       bout_s  [2];
  logic       zero_s  [2];
  logic       ovf_s   [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(W), .DIGIT(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]), .bin(bin_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .diff(diff_s[0]), .bout(bout_s[0]),
    .zero(zero_s[0]), .ovf(ovf_s[0])
  );

  serial_subtractor #(.WIDTH(W), .DIGIT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]), .bin(bin_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .diff(diff_s[1]), .bout(bout_s[1]),
    .zero(zero_s[1]), .ovf(ovf_s[1])
  );

  function automatic int n_of(input int id);
    return (id == 0) ? 8 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-word integer arithmetic, not slice-by-slice.
  function automatic exp_t model(input int id, input logic [7:0] av, input logic [7:0] bv,
                                 input logic bi);
    exp_t m;
    int   r;
    int   s;
    r = int'(av) - int'(bv) - int'(bi);
    s = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    m.id   = id;
    m.diff = r[7:0];
    m.bout = (r < 0);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    m.zero = (r[7:0] == 8'h00);
    m.ovf  = (s < -128) || (s > 127);
`else
    m.zero = 1'b0;
    m.ovf  = 1'b0;
`endif
    m.due  = 0;
    return m;
  endfunction

  // Monitor: pop and compare on each done pulse, and flag missed or unexpected pulses.
  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      if (done_s[id] === 1'b1) begin
        if (q.size() == 0 || q[0].id != id) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done dut%0d actual=1 expected=0 cycle=%0d", id, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("diff_dut%0d", id), 32'(diff_s[id]), 32'(e.diff));
          check($sformatf("bout_dut%0d", id), 32'(bout_s[id]), 32'(e.bout));
          check($sformatf("zero_dut%0d", id), 32'(zero_s[id]), 32'(e.zero));
          check($sformatf("ovf_dut%0d", id),  32'(ovf_s[id]),  32'(e.ovf));
          check($sformatf("latency_dut%0d", id), 32'(cyc), 32'(e.due));
          check($sformatf("busy_in_done_dut%0d", id), 32'(busy_s[id]), 32'd0);
        end
      end
    end
    if (q.size() != 0 && cyc > q[0].due) begin
      checks++;
      errors++;
      $display("FAIL done_timeout dut%0d actual=none expected=cycle%0d", q[0].id, q[0].due);
      void'(q.pop_front());
    end
  end

  // Issue one operation and return in its DONE cycle. When garbage is set,
  // start pulses and operand changes are also driven during RUN.
  task automatic issue(input int id, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input bit garbage);
    exp_t e;
    int   n;
    n = n_of(id);
    @(negedge clk);
    start_s[id] = 1'b1;
    a_s[id]     = av;
    b_s[id]     = bv;
    bin_s[id]   = bi;
    @(posedge clk);
    #1;
    e     = model(id, av, bv, bi);
    e.due = cyc + n;
    q.push_back(e);
    check($sformatf("busy_run_dut%0d", id), 32'(busy_s[id]), 32'd1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start_s[id] = (garbage && i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      a_s[id]     = (i == 0) ? 8'hFF : 8'($urandom);
      b_s[id]     = 8'($urandom);
      bin_s[id]   = 1'($urandom);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int m);
    repeat (m) @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending results", q.size());
    end
  endtask

  initial begin
    for (int id = 0; id < 2; id++) begin
      start_s[id] = 1'b0;
      a_s[id]     = '0;
      b_s[id]     = '0;
      bin_s[id]   = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int id = 0; id < 2; id++) begin
      check("reset_busy", 32'(busy_s[id]), 32'd0);
      check("reset_done", 32'(done_s[id]), 32'd0);
      check("reset_diff", 32'(diff_s[id]), 32'd0);
      check("reset_bout", 32'(bout_s[id]), 32'd0);
      check("reset_zero", 32'(zero_s[id]), 32'd0);
      check("reset_ovf",  32'(ovf_s[id]),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed cases on the bit-serial instance.
    issue(0, 8'h05, 8'h03, 1'b0, 1'b0);
    idle(2);
    issue(0, 8'h00, 8'h01, 1'b0, 1'b0);
    issue(0, 8'h80, 8'h01, 1'b0, 1'b0);      // back-to-back start from DONE
    idle(1);
    issue(0, 8'h55, 8'h11, 1'b0, 1'b1);      // a start during RUN must be ignored
    issue(0, 8'h09, 8'h0A, 1'b0, 1'b0);      // back-to-back start from DONE
    idle(1);

    // Randomized operations with random gaps, some of them back-to-back.
    for (int i = 0; i < 30; i++) begin
      issue(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    issue(0, 8'h55, 8'h11, 1'b0, 1'b0);       // leaves diff nonzero before the abort
    idle(1);
    drain();

    // Abort: assert rst during the third RUN cycle.
    @(negedge clk);
    start_s[0] = 1'b1;
    a_s[0]     = 8'h33;
    b_s[0]     = 8'h11;
    bin_s[0]   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy_s[0]), 32'd0);
    check("abort_done", 32'(done_s[0]), 32'd0);
    check("abort_diff", 32'(diff_s[0]), 32'd0);
    check("abort_bout", 32'(bout_s[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(12);                                   // the monitor reports any stray done
    #1;
    check("abort_busy_after", 32'(busy_s[0]), 32'd0);

    // Digit-parallel instance (DIGIT=4, N=2).
    issue(1, 8'h10, 8'h0F, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 20; i++) begin
      issue(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(1);
    drain();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
